dlram_wr_control: RTL
=====================

Name: dlram_wr_control

Overview:
- Write-side sequencer for the downlink ping-pong RAM. Two banks: bank 0 at addresses 0..37, bank 1 at 64..101.
- Accepts a stream of 10-bit words and fills the banks alternately.
- Flags a full bank to the read controller on DlRAM_wr_state. Releases the bank when the read controller reports it has been read on DlRAM_rd_state.
- Sits between the sample framer upstream and the RAM write port plus read controller downstream.

Parameters:
- DATA_W, 10, RAM word width.
- ADDR_W, 7, RAM address width.
- FRAME_LEN, 38, words per bank fill.
- BANK0_BASE, 0, first address of bank 0.
- BANK1_BASE, 64, first address of bank 1.

Ports:
- clk  in  1  system clock, single clock domain.
- Rst  in  1  synchronous, active-high reset.
- dinEn  in  1  input word valid, one word per asserted cycle.
- din  in  DATA_W  input word.
- frameSync  in  1  one-cycle pulse; restarts the current fill from the bank base.
- DlRAM_rd_state  in  2  level per bank from the read controller: bank read complete.
- DlRAM_wr_state  out  2  level per bank: bank full and awaiting read.
- wrRAMEn  out  1  RAM write enable.
- wrRAMAddr  out  ADDR_W  RAM write address.
- wrRAMData  out  DATA_W  RAM write data.
- activeBank  out  1  bank currently being filled.
- overflow  out  1  one-cycle pulse when a word is dropped.

Behaviour:
- Reset: one clk, Rst high, synchronous. All outputs go to 0. State S_FILL0, wrCnt=0, rdStatePrev=00.
- A reset mid-fill discards the partial frame and clears both wr_state bits.
- States:
  - S_FILL0: fill bank 0.
  - S_FILL1: fill bank 1.
  - S_WAIT0: bank 0 is the next target but is still flagged.
  - S_WAIT1: bank 1 is the next target but is still flagged.
- Write path, in S_FILLb with dinEn=1:
  - Next cycle: wrRAMEn=1, wrRAMAddr=BASEb+wrCnt, wrRAMData=din. Latency is exactly 1 cycle.
  - wrCnt increments by 1.
  - wrRAMEn is 0 in every cycle with no accepted word.
- Bank completion: the write with wrCnt==FRAME_LEN-1 completes bank b.
  - Next cycle: DlRAM_wr_state[b]=1 (same cycle as that final write), wrCnt=0.
  - Target becomes bank !b. Next state is S_FILL(!b) if DlRAM_wr_state[!b]==0, else S_WAIT(!b).
- S_WAITb:
  - Every dinEn=1 word is dropped, with overflow=1 in the following cycle and no RAM write.
  - Moves to S_FILLb the cycle after DlRAM_wr_state[b] clears.
- Bank release:
  - rdStatePrev registers DlRAM_rd_state.
  - A rising edge on bit b (rd_state[b]=1, prev=0) while DlRAM_wr_state[b]=1 clears DlRAM_wr_state[b] on the next clk.
  - Level-high rd_state without a rising edge never clears a flag. The read controller holds rd_state for about 21 cycles; a stale high must not release a refilled bank.
  - A rising edge on a bank whose flag is 0 is ignored.
- Simultaneous set and release on the same bank in one cycle: the set wins and the flag stays 1.
- Both banks flagged: the writer waits. The read controller serves bank 0 first; no ordering is enforced here.
- frameSync=1:
  - wrCnt=0 next cycle and the partial frame is abandoned. No flag is set.
  - Honoured in S_FILLb; ignored in S_WAITb.
  - If dinEn=1 in the same cycle, that word is written at BASEb+0 and wrCnt becomes 1.
- activeBank: equals the target bank in all states.
- wrCnt: width ceil(log2(FRAME_LEN)). It never exceeds FRAME_LEN-1.

Optional Feature:
- Macro: DLRAM_WR_DROP_CNT_EN.
- When defined:
  - Adds output dropCnt[15:0], reset to 0.
  - Increments once per overflow pulse and saturates at 16'hFFFF (no wrap).
- When undefined:
  - Port and counter are absent.
  - overflow pulse behaviour is unchanged.

Test Plan:
- Reset, then 38 consecutive dinEn words 0..37:
  - Writes at addresses 0..37 with matching data.
  - DlRAM_wr_state=01 on the cycle of the address-37 write.
  - activeBank=1 after it.
- Continue 38 words without any rd_state:
  - Bank 1 writes at addresses 64..101.
  - wr_state=11, state S_WAIT0.
  - Next 3 words produce 3 overflow pulses and no wrRAMEn.
- From wr_state=11: pulse rd_state[0] high for 21 cycles:
  - wr_state[0] clears 1 cycle after the rising edge.
  - The next word is written at address 0.
  - rd_state held high does not affect the subsequent refill of bank 0.
- After 20 words into bank 0, assert frameSync together with dinEn:
  - That word is written at address 0.
  - The bank completes only after 37 further words (address 37). No early flag.
- Final word of bank 1 coincides with a rising edge of rd_state[1]:
  - wr_state[1]=1 and stays set.
- Assert Rst mid-fill at wrCnt=15 with wr_state=10:
  - Next cycle all outputs are 0 and the state is S_FILL0.
  - With DLRAM_WR_DROP_CNT_EN, dropCnt is also 0.
  - After 70000 forced drops, dropCnt=16'hFFFF.

Source files
------------

// File: rtl/dlram_wr_control.sv
// Write-side sequencer for the two-bank downlink ping-pong RAM.
// Optional saturating drop counter output enabled by DLRAM_WR_DROP_CNT_EN.
module dlram_wr_control #(
  parameter int DATA_W     = 10,
  parameter int ADDR_W     = 7,
  parameter int FRAME_LEN  = 38,
  parameter int BANK0_BASE = 0,
  parameter int BANK1_BASE = 64
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              dinEn,
  input  logic [DATA_W-1:0] din,
  input  logic              frameSync,
  input  logic [1:0]        DlRAM_rd_state,
  output logic [1:0]        DlRAM_wr_state,
  output logic              wrRAMEn,
  output logic [ADDR_W-1:0] wrRAMAddr,
  output logic [DATA_W-1:0] wrRAMData,
  output logic              activeBank,
`ifdef DLRAM_WR_DROP_CNT_EN
  output logic              overflow,
  output logic [15:0]       dropCnt
`else
  output logic              overflow
`endif
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_WAIT0 = 2'd2,
    S_WAIT1 = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wrCnt;
  logic [1:0]        rdStatePrev;

  logic              bank;
  logic              filling;
  logic              last_word;
  logic [1:0]        rd_rise;
  logic [1:0]        release_req;
  logic [1:0]        set_req;
  logic [ADDR_W-1:0] bank_base;
  logic [ADDR_W-1:0] cnt_addr;

  always_comb begin
    bank        = (state == S_FILL1) || (state == S_WAIT1);
    filling     = (state == S_FILL0) || (state == S_FILL1);
    // Only a fresh rising edge releases a bank; a held-high level is stale.
    rd_rise     = DlRAM_rd_state & ~rdStatePrev;
    release_req = rd_rise & DlRAM_wr_state;
    last_word   = filling && dinEn && !frameSync &&
                  (wrCnt == CNT_W'(FRAME_LEN - 1));
    set_req     = '0;
    if (last_word) set_req[bank] = 1'b1;
    bank_base   = bank ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
    cnt_addr    = frameSync ? '0 : ADDR_W'(wrCnt);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state          <= S_FILL0;
      wrCnt          <= '0;
      rdStatePrev    <= '0;
      DlRAM_wr_state <= '0;
      wrRAMEn        <= 1'b0;
      wrRAMAddr      <= '0;
      wrRAMData      <= '0;
      activeBank     <= 1'b0;
      overflow       <= 1'b0;
`ifdef DLRAM_WR_DROP_CNT_EN
      dropCnt        <= '0;
`endif
    end else begin
      rdStatePrev    <= DlRAM_rd_state;
      // Set takes priority over a same-cycle release.
      DlRAM_wr_state <= (DlRAM_wr_state & ~release_req) | set_req;
      wrRAMEn        <= 1'b0;
      overflow       <= 1'b0;
      unique case (state)
        S_FILL0, S_FILL1: begin
          if (dinEn) begin
            wrRAMEn   <= 1'b1;
            wrRAMAddr <= bank_base + cnt_addr;
            wrRAMData <= din;
            if (last_word) begin
              wrCnt      <= '0;
              activeBank <= ~bank;
              if (DlRAM_wr_state[~bank])
                state <= bank ? S_WAIT0 : S_WAIT1;
              else
                state <= bank ? S_FILL0 : S_FILL1;
            end else if (frameSync) begin
              wrCnt <= CNT_W'(1);
            end else begin
              wrCnt <= wrCnt + CNT_W'(1);
            end
          end else if (frameSync) begin
            wrCnt <= '0;
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (dinEn) begin
            overflow <= 1'b1;
`ifdef DLRAM_WR_DROP_CNT_EN
            if (dropCnt != '1) dropCnt <= dropCnt + 16'd1;
`endif
          end
          if (!DlRAM_wr_state[bank])
            state <= bank ? S_FILL1 : S_FILL0;
        end
        default: state <= S_FILL0;
      endcase
    end
  end

endmodule
